// File: rtl/band_energy_detector.sv
// Band energy detector: squares each accepted signed sample, sums the squares
// over fixed non-overlapping windows of 2**LOG2_WIN samples, publishes the
// window energy with a one-cycle strobe and drives a hysteretic, debounced
// band-activity flag.
module band_energy_detector #(
  parameter int LOG2_WIN = 4,
  parameter int HOLD_WIN = 2,
  parameter int ENERGY_W = 15 + LOG2_WIN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [7:0]   data_in,
  input  logic [ENERGY_W-1:0] thresh_on,
  input  logic [ENERGY_W-1:0] thresh_off,
  output logic [ENERGY_W-1:0] energy_out,
  output logic                energy_valid,
  output logic                detect,
  output logic [LOG2_WIN-1:0] win_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;
  logic                detect_next;

  logic [7:0]          mag;
  logic [14:0]         sq_next;
  logic [14:0]         sq_reg;
  logic                sq_valid;
  logic                sq_last;
  logic [ENERGY_W-1:0] acc;
  logic [ENERGY_W-1:0] e_sum;
  logic                win_close;

  // Squaring through the magnitude keeps the product unsigned; -128 maps to
  // 128 and its square (16384) still fits the 15-bit square register.
  assign mag       = data_in[7] ? (~data_in + 8'd1) : data_in;
  assign sq_next   = {7'd0, mag} * {7'd0, mag};
  assign win_close = sq_valid & sq_last;
  assign e_sum     = acc + ENERGY_W'(sq_reg);

  // Stage 1: register the square of each accepted sample and track the
  // position inside the window so the closing sample can be tagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_reg   <= '0;
      sq_valid <= 1'b0;
      sq_last  <= 1'b0;
      win_idx  <= '0;
    end else begin
      sq_valid <= in_valid;
      if (in_valid) begin
        sq_reg  <= sq_next;
        sq_last <= (win_idx == {LOG2_WIN{1'b1}});
        win_idx <= win_idx + 1'b1;
      end
    end
  end

  // Stage 2: accumulate squares; on the closing square publish the total and
  // restart the accumulator so the next window may begin on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      energy_out   <= '0;
      energy_valid <= 1'b0;
    end else begin
      energy_valid <= win_close;
      if (sq_valid) begin
        if (sq_last) begin
          energy_out <= e_sum;
          acc        <= '0;
        end else begin
          acc <= e_sum;
        end
      end
    end
  end

  // Detector state register; detect and the hold counter are registered so
  // they only move on the edge that also raises energy_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      detect <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      detect <= detect_next;
    end
  end

  // Next-state logic: thresholds are only evaluated against a closing window's
  // total; ARM debounces HOLD_WIN consecutive loud windows before asserting.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    detect_next = detect;
    if (win_close) begin
      case (state)
        IDLE: begin
          if (e_sum >= thresh_on) begin
            if (HOLD_WIN == 1) begin
              state_next  = ACTIVE;
              detect_next = 1'b1;
            end else begin
              state_next = ARM;
              cnt_next   = 4'd1;
            end
          end
        end
        ARM: begin
          if (e_sum >= thresh_on) begin
            if (cnt + 4'd1 == 4'(HOLD_WIN)) begin
              state_next  = ACTIVE;
              detect_next = 1'b1;
              cnt_next    = 4'd0;
            end else begin
              cnt_next = cnt + 4'd1;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end
        end
        ACTIVE: begin
          if (e_sum < thresh_off) begin
            state_next  = IDLE;
            detect_next = 1'b0;
          end
        end
        default: begin
          state_next  = IDLE;
          cnt_next    = 4'd0;
          detect_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_band_energy_detector.sv
// Bench for band_energy_detector: two instances (HOLD_WIN=2 and HOLD_WIN=1)
// share one stimulus stream; expected window results are queued when the
// closing sample is driven and popped when energy_valid appears.
module tb_band_energy_detector;

  localparam int LOG2_WIN = 4;
  localparam int WIN      = 1 << LOG2_WIN;
  localparam int ENERGY_W = 15 + LOG2_WIN;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic signed [7:0]   data_in;
  logic [ENERGY_W-1:0] thresh_on;
  logic [ENERGY_W-1:0] thresh_off;

  logic [ENERGY_W-1:0] energy_out2, energy_out1;
  logic                energy_valid2, energy_valid1;
  logic                detect2, detect1;
  logic [LOG2_WIN-1:0] win_idx2, win_idx1;

  typedef struct {
    int energy;
    bit det2;
    bit det1;
    int cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference detector model, index 0 for HOLD_WIN=2, index 1 for HOLD_WIN=1
  int m_state[2];
  int m_cnt[2];
  bit m_det[2];
  int hold_of[2] = '{2, 1};
  int m_sum;
  int m_idx;

  band_energy_detector #(.LOG2_WIN(LOG2_WIN), .HOLD_WIN(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .thresh_on(thresh_on), .thresh_off(thresh_off),
    .energy_out(energy_out2), .energy_valid(energy_valid2),
    .detect(detect2), .win_idx(win_idx2)
  );

  band_energy_detector #(.LOG2_WIN(LOG2_WIN), .HOLD_WIN(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .thresh_on(thresh_on), .thresh_off(thresh_off),
    .energy_out(energy_out1), .energy_valid(energy_valid1),
    .detect(detect1), .win_idx(win_idx1)
  );

  // Free-running clock and cycle counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance the model detectors on a window close with total e
  task automatic modelClose(input int e);
    for (int k = 0; k < 2; k++) begin
      case (m_state[k])
        0: if (e >= int'(thresh_on)) begin
             if (hold_of[k] == 1) begin m_state[k] = 2; m_det[k] = 1'b1; end
             else begin m_state[k] = 1; m_cnt[k] = 1; end
           end
        1: if (e >= int'(thresh_on)) begin
             m_cnt[k]++;
             if (m_cnt[k] == hold_of[k]) begin m_state[k] = 2; m_det[k] = 1'b1; m_cnt[k] = 0; end
           end else begin
             m_state[k] = 0; m_cnt[k] = 0;
           end
        default: if (e < int'(thresh_off)) begin m_state[k] = 0; m_det[k] = 1'b0; end
      endcase
    end
  endtask

  // Drive one cycle; accepted samples update the model and, on the closing
  // sample, push the expected result due one edge later
  task automatic applyStimulus(input bit v, input logic signed [7:0] d);
    exp_t e;
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
    if (v) begin
      m_sum += int'(d) * int'(d);
      m_idx = (m_idx + 1) % WIN;
      checkOutput("win_idx2", 32'(win_idx2), 32'(m_idx));
      checkOutput("win_idx1", 32'(win_idx1), 32'(m_idx));
      if (m_idx == 0) begin
        modelClose(m_sum);
        e.energy = m_sum;
        e.det2   = m_det[0];
        e.det1   = m_det[1];
        e.cyc    = cyc + 1;
        sb.push_back(e);
        m_sum = 0;
      end
    end
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_sum = 0;
    m_idx = 0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_det[k] = 1'b0;
    end
    checkOutput("rst_energy_out", 32'(energy_out2), 0);
    checkOutput("rst_energy_valid", 32'(energy_valid2), 0);
    checkOutput("rst_detect2", 32'(detect2), 0);
    checkOutput("rst_detect1", 32'(detect1), 0);
    checkOutput("rst_win_idx", 32'(win_idx2), 0);
  endtask

  // One full window: first half of samples a, second half b
  task automatic runWindow(input logic signed [7:0] a, input logic signed [7:0] b, input bit gap);
    for (int i = 0; i < WIN; i++) begin
      applyStimulus(1'b1, (i < WIN / 2) ? a : b);
      if (gap) applyStimulus(1'b0, '0);
    end
  endtask

  // Change thresholds only after any pending window close has been evaluated
  task automatic setThresh(input int on, input int off);
    applyStimulus(1'b0, '0);
    thresh_on  = ENERGY_W'(on);
    thresh_off = ENERGY_W'(off);
  endtask

  // Scoreboard consumer: every energy_valid pulse must match the queue head
  always @(negedge clk) begin
    if (energy_valid2 === 1'b1 || energy_valid1 === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("valid2", 32'(energy_valid2), 1);
        checkOutput("valid1", 32'(energy_valid1), 1);
        checkOutput("energy2", 32'(energy_out2), 32'(e.energy));
        checkOutput("energy1", 32'(energy_out1), 32'(e.energy));
        checkOutput("detect2", 32'(detect2), 32'(e.det2));
        checkOutput("detect1", 32'(detect1), 32'(e.det1));
        checkOutput("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    thresh_on  = '1;
    thresh_off = '0;
    doReset();

    $display("[TB] window of 10s at half rate, thresholds max");
    runWindow(8'sd10, 8'sd10, 1'b1);
    applyStimulus(1'b0, '0);
    checkOutput("idx_wrap", 32'(win_idx2), 0);

    $display("[TB] two full-scale windows with in_valid held high");
    runWindow(-8'sd128, -8'sd128, 1'b0);
    runWindow(-8'sd128, -8'sd128, 1'b0);

    $display("[TB] alternating quiet/loud windows, on=5000 off=1000");
    setThresh(5000, 1000);
    runWindow(8'sd5, 8'sd5, 1'b1);
    runWindow(-8'sd20, -8'sd20, 1'b1);
    runWindow(8'sd5, 8'sd5, 1'b1);
    runWindow(-8'sd20, -8'sd20, 1'b1);
    runWindow(8'sd5, 8'sd5, 1'b1);

    $display("[TB] 6400, 6400, 2000, 400 hysteresis sequence");
    runWindow(-8'sd20, -8'sd20, 1'b1);
    runWindow(-8'sd20, -8'sd20, 1'b1);
    runWindow(8'sd15, 8'sd5, 1'b1);
    runWindow(8'sd5, 8'sd5, 1'b1);

    $display("[TB] energy equal to thresh_on then thresh_off");
    setThresh(6400, 400);
    runWindow(-8'sd20, -8'sd20, 1'b1);
    runWindow(8'sd5, 8'sd5, 1'b1);
    applyStimulus(1'b0, '0);
    checkOutput("held_detect1", 32'(detect1), 1);

    $display("[TB] reset after a partial window");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'sd10);
    doReset();
    runWindow(8'sd3, 8'sd3, 1'b1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0);
    checkOutput("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/band_energy_detector.md
Name: band_energy_detector

Overview:
- Downstream consumer of the bandpass decimator output.
- Squares each accepted signed 8-bit filtered sample and sums the squares over fixed, non-overlapping windows of 2**LOG2_WIN samples.
- Publishes the window energy with a one-cycle strobe.
- Drives a hysteretic, debounced band-activity flag (`detect`) for downstream control logic.

Parameters:
- LOG2_WIN, 4, log2 of window length in samples (window = 16 by default); legal range 1..8.
- HOLD_WIN, 2, consecutive windows at or above thresh_on required to assert detect; legal range 1..15.
- ENERGY_W, 15+LOG2_WIN, energy/threshold width. Derived; must not be overridden smaller.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, data_in holds a new sample this cycle (from decimator, nominally every 2nd cycle; any pattern legal).
- data_in, input, 8, signed filtered sample (two's complement).
- thresh_on, input, ENERGY_W, unsigned assert threshold.
- thresh_off, input, ENERGY_W, unsigned release threshold.
- energy_out, output, ENERGY_W, unsigned sum of squares of last completed window.
- energy_valid, output, 1, one-cycle pulse: energy_out updated.
- detect, output, 1, band-activity level.
- win_idx, output, LOG2_WIN, index of next sample within current window (debug/sync).

Behaviour:
- Reset (synchronous, highest priority):
  - energy_out=0, energy_valid=0, detect=0, win_idx=0.
  - Accumulator=0, square pipeline register and its valid=0.
  - FSM=IDLE, hold counter=0.
  - Reset mid-window discards the partial window and any in-flight square; no energy_valid results from pre-reset samples.
- Stage 1, edge t, in_valid=1:
  - sq_reg <= data_in*data_in (unsigned, 15 bits; max 16384 at -128).
  - sq_valid <= 1.
  - sq_last <= (win_idx == 2**LOG2_WIN-1).
  - win_idx increments, wrapping to 0 after the last index.
- Stage 1, in_valid=0: sq_valid <= 0; win_idx holds.
- Stage 2, edge t+1, sq_valid=1 and sq_last=0: acc <= acc + sq_reg.
- Stage 2, edge t+1, sq_valid=1 and sq_last=1:
  - E = acc + sq_reg.
  - energy_out <= E, energy_valid <= 1, acc <= 0.
  - FSM evaluates E (see below).
- Back-to-back windows: a new window's first sample may be squared in the same cycle the previous window closes. No samples are lost at any in_valid rate, including in_valid held high.
- energy_valid is high only in the cycle after the closing edge; 0 otherwise.
- Latency: last sample of a window sampled at edge t produces energy_out/energy_valid/detect visible after edge t+1.
- Width: ENERGY_W = 15+LOG2_WIN guarantees no overflow. Worst case is (2**LOG2_WIN)*16384, e.g. 262144 for 16 samples of -128, which fits in 19 bits. No saturation logic.
- FSM evaluates only on window close; thresholds are sampled at that edge:
  - IDLE:
    - E >= thresh_on and HOLD_WIN=1 → ACTIVE, detect <= 1.
    - E >= thresh_on and HOLD_WIN>1 → ARM, cnt <= 1.
    - Else stay IDLE.
  - ARM:
    - E >= thresh_on: cnt <= cnt+1. If cnt+1 == HOLD_WIN → ACTIVE, detect <= 1, cnt <= 0.
    - E < thresh_on → IDLE, cnt <= 0.
  - ACTIVE:
    - E < thresh_off → IDLE, detect <= 0.
    - Else stay ACTIVE.
- Equality: E == thresh_on counts as above. E == thresh_off keeps ACTIVE.
- thresh_off > thresh_on is not flagged; transitions follow the rules above literally.
- detect changes only on the same edge that raises energy_valid.

Test Plan:
- Default params; data_in=10 for 16 samples, in_valid every 2nd cycle; thresholds max → single energy_valid pulse 2 edges after the 16th accepted sample, energy_out=1600, detect=0, win_idx back to 0.
- data_in=-128, in_valid held high for 32 cycles → energy_valid pulses exactly 16 cycles apart, each with energy_out=262144, no overflow, no dropped sample.
- Alternating windows: 16×5 (E=400) and 16×(-20) (E=6400); thresh_on=5000, thresh_off=1000, HOLD_WIN=2 → IDLE→ARM→IDLE→ARM…; detect never asserts.
- Two consecutive E=6400 windows, then E=2000, then E=400 → detect rises on the 2nd window close, stays 1 at E=2000 (≥ off), falls at E=400.
- Boundary: E exactly equal to thresh_on, then to thresh_off, with HOLD_WIN=1 → asserts on the first, stays asserted on the second.
- Reset pulsed after 7 samples of a window, then 16 samples of 3 → no pulse from the partial window; next pulse energy_out=144; detect=0, FSM=IDLE after reset.
